// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/data/grant bundle between N masters and the bus arbiter
// Parameters: N masters, DATA_W data bits per master.
// master modport (requesters): drive req, data_in; observe ack, grant_id, busy, req_out, data_out.
// slave modport (arbiter): observe req, data_in; drive ack, grant_id, busy, req_out, data_out.
interface bus_arbiter_if #(
    parameter int N      = 4,
    parameter int DATA_W = 2
);
    localparam int GW = $clog2(N);
    logic [N-1:0]        req;
    logic [N*DATA_W-1:0] data_in;
    logic [N-1:0]        ack;
    logic [GW-1:0]       grant_id;
    logic                busy;
    logic                req_out;
    logic [DATA_W-1:0]   data_out;
    modport master (output req, data_in, input ack, grant_id, busy, req_out, data_out);
    modport slave  (input req, data_in, output ack, grant_id, busy, req_out, data_out);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one registered bus between N masters
// Ports: clk (rising-edge clock), reset (sync active-high), bus (bus_arbiter_if.slave:
//   req/data_in from masters; ack one-hot, grant_id, busy, registered req_out/data_out).
// Optional macro BUS_ARB_TIMEOUT_EN: force-release an owner after HOLD_MAX grant cycles.
module bus_arbiter #(
    parameter int N        = 4,
    parameter int DATA_W   = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    localparam int GW = $clog2(N);
    if (N < 2 || HOLD_MAX < 1) begin : g_bad_cfg
        $error("bus_arbiter: N must be >= 2 and HOLD_MAX >= 1");
    end
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t            state;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     pick;
    logic [N-1:0]      ack;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              release_now;
    logic [GW-1:0]     next_ptr;
    // Scan from the highest rotation down so the lowest rotation offset from rr_ptr wins.
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_ptr) + k) % N]) pick = GW'((int'(rr_ptr) + k) % N);
        end
    end
    assign next_ptr = (grant_id == GW'(N - 1)) ? '0 : grant_id + 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold;
    // hold counts completed grant cycles; the HOLD_MAX-th grant edge releases.
    assign release_now = !bus.req[grant_id] || (hold == HW'(HOLD_MAX - 1));
    always_ff @(posedge clk) begin
        if (reset || state != GRANT) hold <= '0;
        else if (!release_now) hold <= hold + 1'b1;
    end
`else
    assign release_now = !bus.req[grant_id];
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            ack      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            req_out  <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        ack      <= {{(N-1){1'b0}}, 1'b1} << pick;
                        grant_id <= pick;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ack      <= '0;
                        grant_id <= '0;
                        busy     <= 1'b0;
                        req_out  <= 1'b0;
                        data_out <= '0;
                        rr_ptr   <= next_ptr;
                        state    <= RELEASE;
                    end else begin
                        req_out  <= 1'b1;
                        data_out <= bus.data_in[grant_id*DATA_W +: DATA_W];
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.ack      = ack;
    assign bus.grant_id = grant_id;
    assign bus.busy     = busy;
    assign bus.req_out  = req_out;
    assign bus.data_out = data_out;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench with a behavioural arbiter model checked every cycle
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int DW = 2;
    localparam int HM = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    bus_arbiter_if #(.N(N), .DATA_W(DW)) bus ();
    bus_arbiter #(.N(N), .DATA_W(DW), .HOLD_MAX(HM)) dut (.clk(clk), .reset(reset), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    // Model: owner index (-1 = nobody), a one-cycle release gap, pointer, hold count.
    int          m_owner = -1;
    bit          m_rel = 1'b0;
    int          m_rr = 0;
    int          m_hold = 0;
    logic        m_req_out = 1'b0;
    logic [DW-1:0] m_data = '0;
    bit          live = 1'b0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        live = 1'b1;
        if (reset) begin
            m_owner = -1; m_rel = 1'b0; m_rr = 0; m_req_out = 1'b0; m_data = '0;
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && bus.req[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
            m_hold = 0;
        end else begin
            m_hold++;
            if (!bus.req[m_owner] || (TO && m_hold >= HM)) begin
                m_rr = (m_owner + 1) % N;
                m_owner = -1; m_rel = 1'b1; m_req_out = 1'b0; m_data = '0;
            end else begin
                m_req_out = 1'b1;
                m_data = bus.data_in[m_owner*DW +: DW];
            end
        end
    end
    always @(negedge clk) begin
        if (live) begin
            chk("ack", bus.ack, m_owner >= 0 ? (1 << m_owner) : 0);
            chk("busy", bus.busy, m_owner >= 0);
            chk("grant_id", bus.grant_id, m_owner >= 0 ? m_owner : 0);
            chk("req_out", bus.req_out, m_req_out);
            chk("data_out", bus.data_out, m_data);
        end
    end
    task automatic wait_grant(input int exp_id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.busy && n < 10);
        chk("grant_seen", bus.busy, 1);
        chk("grant_owner", bus.grant_id, exp_id);
        chk("model_owner", m_owner, exp_id);
    endtask
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] m;
        int n;
        bus.req = '1;
        bus.data_in = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", bus.ack, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_req_out", bus.req_out, 0);
            chk("rst_data_out", bus.data_out, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("first_ack", bus.ack, 4'b0001);
        chk("first_model", m_owner, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        bus.data_in = 8'h20;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("single_ack", bus.ack, 4'b0100);
        chk("single_id", bus.grant_id, 2);
        chk("single_req_out0", bus.req_out, 0);
        @(negedge clk);
        chk("single_data", bus.data_out, 2'b10);
        chk("single_req_out1", bus.req_out, 1);
        bus.req = '0;
        @(negedge clk);
        chk("rel_ack", bus.ack, 0);
        chk("rel_busy", bus.busy, 0);
        chk("rel_data", bus.data_out, 0);
        @(negedge clk);
        pulse_reset();
        bus.data_in = 8'b11_10_01_00;
        bus.req = '1;
        for (int r = 0; r < 5; r++) begin
            wait_grant(order[r]);
            repeat (2) @(negedge clk);
            m = '1;
            m[order[r]] = 1'b0;
            bus.req = m;
            @(negedge clk);
            chk("fair_release", bus.busy, 0);
            bus.req = '1;
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        bus.req = 4'b1000;
        wait_grant(3);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("wrap_release", bus.busy, 0);
        bus.req = 4'b1001;
        wait_grant(0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        pulse_reset();
        bus.req = 4'b0011;
        wait_grant(0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy && bus.grant_id == 0) n++;
            else break;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        chk("timeout_hold0", n, HM);
        wait_grant(1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy && bus.grant_id == 1) n++;
            else break;
        end
        chk("timeout_hold1", n, HM);
        wait_grant(0);
`else
        chk("no_timeout_hold", n, 21);
`endif
        bus.req = '0;
        repeat (3) @(negedge clk);
        bus.data_in = 8'h0C;
        bus.req = 4'b0010;
        wait_grant(1);
        @(negedge clk);
        chk("mid_data", bus.data_out, 2'b11);
        chk("mid_req_out", bus.req_out, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", bus.ack, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_req_out", bus.req_out, 0);
        chk("mid_rst_data", bus.data_out, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("regrant_ack", bus.ack, 4'b0010);
        chk("regrant_id", bus.grant_id, 1);
        bus.req = '0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
